// File: rtl/ts_input_sampler.sv
// MPEG2-TS parallel input front end: oversamples the external byte interface on clk2,
// recovers byte strobes, measures the byte-clock period and frames 188-byte packets.
module ts_input_sampler #(
  parameter int         PKT_LEN   = 188,
  parameter logic [7:0] SYNC_BYTE = 8'h47,
  parameter int         LOCK_CNT  = 3,
  parameter int         LOSS_CNT  = 2,
  parameter int         TIMEOUT   = 64,
  parameter int         PERIOD_W  = 8
) (
  input  logic                clk2,
  input  logic                rst,
  input  logic                ts_clk_in,
  input  logic                ts_valid_in,
  input  logic                ts_sync_in,
  input  logic [7:0]          ts_data_in,
  output logic [7:0]          byte_out,
  output logic                byte_valid,
  output logic                pkt_start,
  output logic                pkt_end,
  output logic                locked,
  output logic [PERIOD_W-1:0] clk_period,
  output logic                clk_timeout
);

  localparam int IDX_W  = $clog2(PKT_LEN);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(LOSS_CNT + 1);

  localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(PKT_LEN - 1);
  localparam logic [GOOD_W-1:0]   LOCK_GOAL   = GOOD_W'(LOCK_CNT);
  localparam logic [BAD_W-1:0]    LOSS_GOAL   = BAD_W'(LOSS_CNT);
  localparam logic [PERIOD_W-1:0] TIMEOUT_VAL = PERIOD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_VERIFY,
    ST_LOCKED
  } state_t;

  logic       s1_clk, s2_clk, s3_clk;
  logic       s1_valid, s2_valid;
  logic       s1_sync, s2_sync;
  logic [7:0] s1_data, s2_data;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    byte_idx_reg, byte_idx_next;
  logic [GOOD_W-1:0]   good_cnt_reg, good_cnt_next;
  logic [BAD_W-1:0]    bad_cnt_reg, bad_cnt_next;
  logic [PERIOD_W-1:0] period_cnt_reg;

  logic             clk_edge;
  logic             accept;
  logic             at_check;
  logic             sync_byte;
  logic             timeout_hit;
  logic [IDX_W-1:0] idx_inc;

  // Two-flop synchroniser on every input; only the clock needs the third stage for edge detect.
  always_ff @(posedge clk2) begin
    if (rst) begin
      s1_clk   <= 1'b0;
      s2_clk   <= 1'b0;
      s3_clk   <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_sync  <= 1'b0;
      s2_sync  <= 1'b0;
      s1_data  <= '0;
      s2_data  <= '0;
    end else begin
      s1_clk   <= ts_clk_in;
      s2_clk   <= s1_clk;
      s3_clk   <= s2_clk;
      s1_valid <= ts_valid_in;
      s2_valid <= s1_valid;
      s1_sync  <= ts_sync_in;
      s2_sync  <= s1_sync;
      s1_data  <= ts_data_in;
      s2_data  <= s1_data;
    end
  end

  assign clk_edge    = s2_clk & ~s3_clk;
  assign accept      = clk_edge & s2_valid;
  assign at_check    = (byte_idx_reg == '0);
  assign sync_byte   = s2_sync && (s2_data == SYNC_BYTE);
  assign timeout_hit = !clk_edge && (period_cnt_reg == TIMEOUT_VAL);
  assign idx_inc     = (byte_idx_reg == LAST_IDX) ? '0 : byte_idx_reg + 1'b1;

  // byte_idx is held at 0 throughout HUNT, so the lock-completing byte always sees idx 0.
  always_comb begin
    state_next    = state_reg;
    byte_idx_next = byte_idx_reg;
    good_cnt_next = good_cnt_reg;
    bad_cnt_next  = bad_cnt_reg;
    if (timeout_hit) begin
      state_next    = ST_HUNT;
      byte_idx_next = '0;
      good_cnt_next = '0;
      bad_cnt_next  = '0;
    end else if (accept) begin
      case (state_reg)
        ST_HUNT: begin
          if (sync_byte) begin
            byte_idx_next = IDX_W'(1);
            good_cnt_next = GOOD_W'(1);
            bad_cnt_next  = '0;
            state_next    = (LOCK_CNT == 1) ? ST_LOCKED : ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (at_check && sync_byte) begin
            byte_idx_next = idx_inc;
            good_cnt_next = good_cnt_reg + 1'b1;
            if (good_cnt_reg + 1'b1 == LOCK_GOAL) begin
              state_next   = ST_LOCKED;
              bad_cnt_next = '0;
            end
          end else if (!at_check && sync_byte) begin
            // A well-formed sync at the wrong place becomes the new framing candidate.
            byte_idx_next = IDX_W'(1);
            good_cnt_next = GOOD_W'(1);
          end else if (at_check || s2_sync) begin
            state_next    = ST_HUNT;
            byte_idx_next = '0;
            good_cnt_next = '0;
          end else begin
            byte_idx_next = idx_inc;
          end
        end
        ST_LOCKED: begin
          byte_idx_next = idx_inc;
          if (at_check && sync_byte) begin
            bad_cnt_next = '0;
          end else if (at_check || s2_sync) begin
            if (bad_cnt_reg + 1'b1 == LOSS_GOAL) begin
              state_next    = ST_HUNT;
              byte_idx_next = '0;
              good_cnt_next = '0;
              bad_cnt_next  = '0;
            end else begin
              bad_cnt_next = bad_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_next    = ST_HUNT;
          byte_idx_next = '0;
          good_cnt_next = '0;
          bad_cnt_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      state_reg    <= ST_HUNT;
      byte_idx_reg <= '0;
      good_cnt_reg <= '0;
      bad_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      byte_idx_reg <= byte_idx_next;
      good_cnt_reg <= good_cnt_next;
      bad_cnt_reg  <= bad_cnt_next;
    end
  end

  // Packet flags follow the post-update state so lock entry flags its byte and lock loss does not.
  always_ff @(posedge clk2) begin
    if (rst) begin
      byte_out   <= '0;
      byte_valid <= 1'b0;
      pkt_start  <= 1'b0;
      pkt_end    <= 1'b0;
    end else begin
      byte_valid <= accept;
      pkt_start  <= accept && (state_next == ST_LOCKED) && at_check;
      pkt_end    <= accept && (state_next == ST_LOCKED) && (byte_idx_reg == LAST_IDX);
      if (accept) begin
        byte_out <= s2_data;
      end
    end
  end

  always_ff @(posedge clk2) begin
    if (rst) begin
      period_cnt_reg <= '0;
      clk_period     <= '0;
      clk_timeout    <= 1'b0;
    end else if (clk_edge) begin
      clk_period     <= period_cnt_reg;
      period_cnt_reg <= PERIOD_W'(1);
      clk_timeout    <= 1'b0;
    end else begin
      if (period_cnt_reg != '1) begin
        period_cnt_reg <= period_cnt_reg + 1'b1;
      end
      if (timeout_hit) begin
        clk_timeout <= 1'b1;
      end
    end
  end

  assign locked = (state_reg == ST_LOCKED);

endmodule
